fan_beep_feedback: RTL and testbench
====================================

Name: fan_beep_feedback

Overview:
- Audible feedback transmitter for the fan front panel. It turns one-cycle key events into timed buzzer patterns: short press gives a single short beep, long press a single long beep, mode change a double beep.
- It is the output counterpart of the key press classifiers. It takes their single-cycle pulses and drives the piezo buzzer pin with a gated square-wave tone.
- A 1 ms timebase is derived internally. A one-deep pending slot absorbs one request that arrives while a pattern is playing.

Parameters:
- TICK_DIV, 100_000, clk cycles per 1 ms tick (100 MHz system clock).
- SHORT_MS, 60, length of a short beep, and of each half of a double beep, in ms.
- LONG_MS, 300, length of a long beep in ms.
- GAP_MS, 80, silent gap inside a double beep; also the trailing gap after every pattern.
- TONE_HALF, 25_000, clk cycles per tone half-period (2 kHz at 100 MHz).

Ports:
- clk  input  1  system clock.
- reset_p  input  1  asynchronous, active-high reset.
- req_short  input  1  one-cycle pulse: request a short beep.
- req_long  input  1  one-cycle pulse: request a long beep.
- req_double  input  1  one-cycle pulse: request a double beep.
- buzz_en  output  1  registered; high while a tone segment is sounding.
- buzz_pwm  output  1  registered; square-wave tone to the buzzer pin, low whenever buzz_en is low.
- busy  output  1  registered; high from pattern start through the end of its trailing gap.
- dropped  output  1  registered; one-cycle pulse when a request is discarded.

Behaviour:
- Reset (async): all outputs are 0, FSM is IDLE, pending slot is empty, all counters are 0.
- Request encoding when more than one req_* is high in the same cycle: long > double > short. The lower-priority requests are discarded and dropped pulses once.
- Timebase:
  - tick_cnt counts 0..TICK_DIV-1; tick = (tick_cnt == TICK_DIV-1).
  - tick_cnt is forced to 0 on the cycle a pattern starts, so each segment lasts exactly dur*TICK_DIV clocks.
  - ms_cnt counts ticks within the current segment and clears on every state change.
- FSM states: IDLE, ON1, GAP1, ON2, TAIL.
  - IDLE + request (or non-empty pending slot) on cycle N: load the pattern and enter ON1. buzz_en=1 and busy=1 from cycle N+1 (latency 1).
  - ON1 duration is LONG_MS for a long beep, otherwise SHORT_MS.
  - ON1 end: next state is GAP1 for a double beep, otherwise TAIL.
  - GAP1 (GAP_MS, buzz_en=0) -> ON2 (SHORT_MS) -> TAIL.
  - TAIL (GAP_MS, buzz_en=0, busy=1): at its end, go to ON1 if the pending slot is full (that pattern is consumed and the slot cleared, no IDLE cycle), otherwise go to IDLE with busy=0.
  - A segment ends on the cycle where tick && ms_cnt == dur-1; the new state's outputs appear the next cycle.
- Pending slot:
  - A request while busy=1 is stored if the slot is empty.
  - If the slot is full, the new request is discarded and dropped=1 for one cycle. Exception: a new long request overwrites a stored short or double, with no dropped pulse.
  - A request arriving on the same cycle IDLE starts a pattern from the slot goes into the now-empty slot.
- Tone:
  - tone_cnt runs only while buzz_en=1 and counts 0..TONE_HALF-1. buzz_pwm toggles on wrap.
  - On entry to ON1/ON2, buzz_pwm starts at 1 with tone_cnt=0. On segment exit, buzz_pwm is forced to 0.
- Parameter constraints: SHORT_MS, LONG_MS, GAP_MS >= 1. Counter widths are sized by $clog2 of the parameters.
- Reset asserted mid-pattern silences the buzzer immediately (async) and clears the pending slot.

Test Plan:
Bench uses TICK_DIV=10, SHORT_MS=3, LONG_MS=8, GAP_MS=2, TONE_HALF=2.
- Pulse req_short at cycle 5 -> buzz_en high cycles 6..35, buzz_pwm 1,1,0,0 repeating. busy high cycles 6..55, low at 56. dropped never asserts.
- Pulse req_double -> buzz_en high 30 cycles, low 20, high 30, then busy is held for 20 more cycles. Total busy length is exactly 100 cycles.
- req_long and req_short in the same cycle -> a single 80-cycle tone, dropped pulses once.
- req_short during a long beep, then req_short again -> first is queued and plays right after TAIL with no IDLE cycle between the patterns; second raises dropped.
- Queued short, then req_long while busy -> long replaces the short in the slot, no dropped; the second pattern heard is 80 cycles.
- Assert reset_p mid-ON1 -> buzz_en, buzz_pwm and busy go 0 without waiting for a clk edge. After release with no requests, the FSM stays IDLE and the queued request is not played.

Source files
------------

// File: rtl/fan_beep_feedback.sv
// fan_beep_feedback: turns key-event pulses into timed, gated square-wave buzzer patterns
// (short, long, double beep) with a one-deep pending request slot.
module fan_beep_feedback #(
    parameter int TICK_DIV  = 100_000,
    parameter int SHORT_MS  = 60,
    parameter int LONG_MS   = 300,
    parameter int GAP_MS    = 80,
    parameter int TONE_HALF = 25_000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic req_short,
    input  logic req_long,
    input  logic req_double,
    output logic buzz_en,
    output logic buzz_pwm,
    output logic busy,
    output logic dropped
);
    localparam int ON_MAX = LONG_MS > SHORT_MS ? LONG_MS : SHORT_MS;
    localparam int MS_MAX = ON_MAX > GAP_MS ? ON_MAX : GAP_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int TONE_W = $clog2(TONE_HALF + 1);

    typedef enum logic [2:0] {IDLE, ON1, GAP1, ON2, TAIL} state_t;
    typedef enum logic [1:0] {K_NONE, K_SHORT, K_LONG, K_DOUBLE} kind_t;

    state_t state, state_nx;
    kind_t pat, slot_k, req_k;
    logic slot_v;
    logic [TICK_W-1:0] tick_cnt;
    logic [MS_W-1:0] ms_cnt, dur;
    logic [TONE_W-1:0] tone_cnt;
    logic tick, seg_end, start, consume, has_req, multi, store_path, slot_free;
    logic overwrite, drop, en_nx, busy_nx, drop_nx, entering, wrap;

    assign req_k      = req_long ? K_LONG : req_double ? K_DOUBLE : req_short ? K_SHORT : K_NONE;
    assign has_req    = req_k != K_NONE;
    assign multi      = (req_long & (req_double | req_short)) | (req_double & req_short);
    assign tick       = tick_cnt == TICK_W'(TICK_DIV - 1);
    assign dur        = state == ON1 ? (pat == K_LONG ? MS_W'(LONG_MS) : MS_W'(SHORT_MS))
                      : state == ON2 ? MS_W'(SHORT_MS) : MS_W'(GAP_MS);
    assign seg_end    = tick && ms_cnt == dur - MS_W'(1);
    assign start      = state_nx == ON1 && state != ON1;
    assign consume    = slot_v && start;
    // In IDLE with an empty slot the request starts playing directly instead of being stored
    assign store_path = has_req && !(state == IDLE && !slot_v);
    assign slot_free  = !slot_v || consume;
    assign overwrite  = store_path && !slot_free && req_k == K_LONG && slot_k != K_LONG;
    assign drop       = store_path && !slot_free && !overwrite;
    assign entering   = en_nx && state_nx != state;
    assign wrap       = tone_cnt == TONE_W'(TONE_HALF - 1);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (slot_v || has_req) ? ON1 : IDLE;
            ON1:     state_nx = seg_end ? (pat == K_DOUBLE ? GAP1 : TAIL) : ON1;
            GAP1:    state_nx = seg_end ? ON2 : GAP1;
            ON2:     state_nx = seg_end ? TAIL : ON2;
            TAIL:    state_nx = seg_end ? (slot_v ? ON1 : IDLE) : TAIL;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        en_nx   = state_nx == ON1 || state_nx == ON2;
        busy_nx = state_nx != IDLE;
        drop_nx = multi || drop;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            buzz_en  <= 1'b0;
            busy     <= 1'b0;
            dropped  <= 1'b0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            pat      <= K_NONE;
            slot_v   <= 1'b0;
            slot_k   <= K_NONE;
        end else begin
            buzz_en  <= en_nx;
            busy     <= busy_nx;
            dropped  <= drop_nx;
            tick_cnt <= (start || tick) ? '0 : tick_cnt + TICK_W'(1);
            ms_cnt   <= (state_nx != state || state == IDLE) ? '0 : tick ? ms_cnt + MS_W'(1) : ms_cnt;
            if (start) pat <= slot_v ? slot_k : req_k;
            if (store_path && (slot_free || overwrite)) begin
                slot_v <= 1'b1;
                slot_k <= req_k;
            end else if (consume) begin
                slot_v <= 1'b0;
            end
        end
    end

    // Tone restarts high on every segment entry so each beep begins identically
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            tone_cnt <= '0;
            buzz_pwm <= 1'b0;
        end else if (entering) begin
            tone_cnt <= '0;
            buzz_pwm <= 1'b1;
        end else if (en_nx) begin
            tone_cnt <= wrap ? '0 : tone_cnt + TONE_W'(1);
            buzz_pwm <= buzz_pwm ^ wrap;
        end else begin
            tone_cnt <= '0;
            buzz_pwm <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fan_beep_feedback.sv
// tb_fan_beep_feedback: vector table plus corner sequences; each busy window is
// measured and compared against an expectation queued when the stimulus was driven.
module tb_fan_beep_feedback;
    logic clk, reset_p, req_short, req_long, req_double;
    logic buzz_en, buzz_pwm, busy, dropped;

    fan_beep_feedback #(
        .TICK_DIV(10), .SHORT_MS(3), .LONG_MS(8), .GAP_MS(2), .TONE_HALF(2)
    ) dut (
        .clk(clk), .reset_p(reset_p), .req_short(req_short), .req_long(req_long),
        .req_double(req_double), .buzz_en(buzz_en), .buzz_pwm(buzz_pwm),
        .busy(busy), .dropped(dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int busy_len; int en_len; int segs; int drops;} win_t;
    typedef struct {logic s; logic l; logic d; int busy_len; int en_len; int segs; int drops;} vec_t;

    win_t exp_q[$];
    vec_t vecs[7];
    int checks = 0, errors = 0;
    int blen = 0, elen = 0, segs = 0, dacc = 0;
    logic busy_q = 1'b0, en_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic l, input logic d);
        @(negedge clk);
        req_short = s; req_long = l; req_double = d;
        @(negedge clk);
        req_short = 0; req_long = 0; req_double = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
        end
        repeat (3) @(negedge clk);
    endtask

    // Measures each busy window and compares it with the oldest queued expectation
    always @(negedge clk) begin
        if (reset_p) begin
            blen = 0; elen = 0; segs = 0; dacc = 0; busy_q = 0; en_q = 0;
        end else begin
            chk("pwm_gated", buzz_pwm & ~buzz_en, 0);
            if (dropped) dacc++;
            if (busy) begin
                blen++;
                if (buzz_en) elen++;
                if (buzz_en && !en_q) segs++;
            end
            if (!busy && busy_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: busy window of %0d cycles, required none", blen);
                end else begin
                    win_t w;
                    w = exp_q.pop_front();
                    chk("busy_len", blen, w.busy_len);
                    chk("en_len", elen, w.en_len);
                    chk("segments", segs, w.segs);
                    chk("drops", dacc, w.drops);
                end
                blen = 0; elen = 0; segs = 0; dacc = 0;
            end
            busy_q = busy;
            en_q = buzz_en;
        end
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0,  50, 30, 1, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 100, 60, 2, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 100, 80, 1, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 100, 80, 1, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 100, 60, 2, 1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 100, 80, 1, 1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 100, 80, 1, 1};
        reset_p = 1; req_short = 0; req_long = 0; req_double = 0;
        #1;
        chk("reset_en", buzz_en, 0);
        chk("reset_pwm", buzz_pwm, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dropped", dropped, 0);
        repeat (3) @(negedge clk);
        reset_p = 0;
        repeat (2) @(negedge clk);

        // Cycle-exact short beep: tone 30 cycles at 1,1,0,0; busy 50 cycles
        exp_q.push_back('{50, 30, 1, 0});
        @(negedge clk) req_short = 1;
        @(negedge clk) req_short = 0;
        for (int k = 0; k < 56; k++) begin
            chk($sformatf("short_en[%0d]", k), buzz_en, k < 30);
            chk($sformatf("short_busy[%0d]", k), busy, k < 50);
            chk($sformatf("short_pwm[%0d]", k), buzz_pwm, (k < 30) && ((k / 2) % 2 == 0));
            chk($sformatf("short_dropped[%0d]", k), dropped, 0);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{vecs[i].busy_len, vecs[i].en_len, vecs[i].segs, vecs[i].drops});
            pulse(vecs[i].s, vecs[i].l, vecs[i].d);
            wait_idle();
        end

        // Long, queued short, second short dropped; queued one follows with no IDLE cycle
        exp_q.push_back('{150, 110, 2, 1});
        pulse(0, 1, 0);
        repeat (10) @(negedge clk);
        pulse(1, 0, 0);
        repeat (10) @(negedge clk);
        pulse(1, 0, 0);
        wait_idle();

        // Queued short is replaced by a later long without a dropped pulse
        exp_q.push_back('{150, 110, 2, 0});
        pulse(1, 0, 0);
        repeat (5) @(negedge clk);
        pulse(1, 0, 0);
        repeat (5) @(negedge clk);
        pulse(0, 1, 0);
        wait_idle();

        // Async reset mid-ON1 with a request queued
        pulse(0, 1, 0);
        repeat (5) @(negedge clk);
        pulse(1, 0, 0);
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_en", buzz_en, 1);
        #2 reset_p = 1;
        #1;
        chk("async_reset_en", buzz_en, 0);
        chk("async_reset_pwm", buzz_pwm, 0);
        chk("async_reset_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset_p = 0;
        begin
            int bc = 0;
            repeat (100) begin
                @(negedge clk);
                if (busy) bc++;
            end
            chk("post_reset_idle", bc, 0);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
